// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake.
// Stage 0 registers the bitwise propagate/generate terms. The prefix levels
// follow, with a register after every REG_EVERY levels except the last.
// The output register holds sum, carry-out and signed overflow.
// All stages advance together on one global enable.
module ks_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned W      = WIDTH;
  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned R      = (REG_EVERY < 1) ? 1 : REG_EVERY;
  // Index of the last prefix stage register; 0 means only the stage-0 register.
  localparam int unsigned NREG   = (LEVELS - 1) / R;

  if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("ks_adder_pipe: WIDTH must be a power of two in 4..64");
  end
  if ((REG_EVERY < 1) || (REG_EVERY > int'(LEVELS))) begin : g_bad_reg_every
    $error("ks_adder_pipe: REG_EVERY must be in 1..log2(WIDTH)");
  end

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } gp_t;

  // Apply the Kogge-Stone levels lo..hi-1. At level k, bit i merges with bit
  // i-2^k. Shifting whole vectors expresses that merge. Bits below 2^k see
  // zero generate and a forced-one propagate, so they pass through unchanged.
  function automatic gp_t span(input gp_t x, input int unsigned lo, input int unsigned hi);
    gp_t              y;
    logic [WIDTH-1:0] low_mask;
    int unsigned      d;
    y = x;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      if ((k >= lo) && (k < hi)) begin
        d        = 32'd1 << k;
        low_mask = ({{(WIDTH-1){1'b0}}, 1'b1} << d) - {{(WIDTH-1){1'b0}}, 1'b1};
        y.g      = y.g | (y.p & (y.g << d));
        y.p      = y.p & ((y.p << d) | low_mask);
      end
    end
    return y;
  endfunction

  logic             adv;
  logic [W-1:0]     b_eff;
  logic             vld_d [0:NREG];
  logic             vld_q [0:NREG];
  gp_t              gp_d  [0:NREG];
  gp_t              gp_q  [0:NREG];
  gp_t              gp_src[0:NREG];
  logic [W-1:0]     ps_d  [0:NREG];
  logic [W-1:0]     ps_q  [0:NREG];
  logic             c0_d  [0:NREG];
  logic             c0_q  [0:NREG];
  logic [TAG_W-1:0] tag_d [0:NREG];
  logic [TAG_W-1:0] tag_q [0:NREG];
  gp_t              gp_fin;

  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     out_sum_d, out_sum_q;
  logic             out_cout_d, out_cout_q;
  logic             out_ovf_d, out_ovf_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;

  // Prefix input of each stage; stage 0 folds the carry-in into the bit-0 generate.
  always_comb begin
    for (int unsigned s = 0; s <= NREG; s++) begin
      gp_src[s] = gp_q[s];
    end
    gp_src[0].g[0] = gp_q[0].g[0] | (gp_q[0].p[0] & c0_q[0]);
  end

  // Next-state for every stage register and the output register.
  always_comb begin
    b_eff     = in_sub ? ~in_b : in_b;
    vld_d[0]  = in_valid && adv;
    gp_d[0].p = in_a ^ b_eff;
    gp_d[0].g = in_a & b_eff;
    ps_d[0]   = in_a ^ b_eff;
    c0_d[0]   = in_sub | in_cin;
    tag_d[0]  = in_tag;
    for (int unsigned s = 1; s <= NREG; s++) begin
      vld_d[s] = vld_q[s-1];
      gp_d[s]  = span(gp_src[s-1], (s - 1) * R, s * R);
      ps_d[s]  = ps_q[s-1];
      c0_d[s]  = c0_q[s-1];
      tag_d[s] = tag_q[s-1];
    end
    gp_fin      = span(gp_src[NREG], NREG * R, LEVELS);
    out_valid_d = vld_q[NREG];
    // After the fold, G[i-1] is the carry into bit i. Bit 0 takes c0 directly.
    out_sum_d   = ps_q[NREG] ^ {gp_fin.g[W-2:0], c0_q[NREG]};
    out_cout_d  = gp_fin.g[W-1];
    out_ovf_d   = gp_fin.g[W-1] ^ gp_fin.g[W-2];
    out_tag_d   = tag_q[NREG];
  end

  // All registers shift together when the output is free or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s <= NREG; s++) begin
        vld_q[s] <= 1'b0;
        gp_q[s]  <= '0;
        ps_q[s]  <= '0;
        c0_q[s]  <= 1'b0;
        tag_q[s] <= '0;
      end
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      for (int unsigned s = 0; s <= NREG; s++) begin
        vld_q[s] <= vld_d[s];
        gp_q[s]  <= gp_d[s];
        ps_q[s]  <= ps_d[s];
        c0_q[s]  <= c0_d[s];
        tag_q[s] <= tag_d[s];
      end
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_tag_q   <= out_tag_d;
    end
  end

endmodule
